float_op_scheduler: RTL
=======================

FLOAT_OP_SCHEDULER -- requirements
Module: float_op_scheduler

Interface
REQ-001 The block SHALL have parameter NM, default 10, meaning mantissa width of the shared float format.
REQ-002 The block SHALL have parameter NE, default 5, meaning exponent width; operand width W = 1+NE+NM, packed {s,e,m}.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning max WAIT cycles before abort (range 2..255).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  2  per-requester command valid (bit i = requester i).
REQ-007 req_ready  output  2  per-requester command accept.
REQ-008 req_op  input  4  2 bits per requester: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 req_a, req_b  input  2*W each  operands per requester (requester i in bits [i*W +: W]).
REQ-010 fpu_start  output  1  one-cycle start pulse to shared float unit.
REQ-011 fpu_op  output  2; fpu_a, fpu_b  output  W each  latched command to unit.
REQ-012 fpu_done  input  1; fpu_result  input  W  unit completion pulse and result.
REQ-013 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-014 rsp_id  output  1; rsp_result  output  W; rsp_err  output  1  owner, result, timeout flag.
REQ-015 busy  output  1  high whenever state != IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-017 In IDLE, grant SHALL go to the sole valid requester; if both valid, to the requester not in last_id (round robin).
REQ-018 req_ready SHALL be combinational: only bit g (granted) high, only in IDLE, only when req_valid[g]; never both bits.
REQ-019 On req_valid[g] & req_ready[g], op/a/b SHALL be latched, rsp_id := g, next state ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle with fpu_start=1, then WAIT with timer cleared to 0.
REQ-021 fpu_op/fpu_a/fpu_b SHALL hold the latched values stable from ISSUE through RESP.
REQ-022 In WAIT, timer SHALL increment each cycle; fpu_done SHALL latch fpu_result into rsp_result, rsp_err=0, next RESP.
REQ-023 If timer == TIMEOUT-1 without fpu_done, next state SHALL be RESP with rsp_result=0, rsp_err=1.
REQ-024 fpu_done and timeout in the same cycle: fpu_done SHALL win (err=0).
REQ-025 fpu_done in IDLE, ISSUE or RESP SHALL be ignored (no state or output change).
REQ-026 In RESP, rsp_valid=1 with rsp_id/rsp_result/rsp_err stable until rsp_ready; on rsp_valid & rsp_ready, last_id := rsp_id, next IDLE.
REQ-027 Latency: accept in cycle T -> fpu_start in T+1; fpu_done in cycle D -> rsp_valid from D+1; new accept earliest cycle after response handshake.
REQ-028 Only one operation SHALL be outstanding; requests wait (ready low) while busy.
REQ-029 Op encoding SHALL pass unchanged to fpu_op; the block performs no arithmetic on operands.

Reset
REQ-030 On reset: state IDLE, last_id=1 (requester 0 wins first tie), timer=0, req_ready=0 during reset cycle, fpu_start=0, fpu_op=0, fpu_a=fpu_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0.
REQ-031 Reset in any state SHALL abandon the operation; a later fpu_done for it SHALL be ignored.

Verification
REQ-032 Single op: req0 add a=0x3C00 (1.0), b=0x4000 (2.0), NM=10/NE=5; unit returns 0x4200 after 3 cycles -> fpu_start 1 cycle after accept, rsp_valid next cycle after done, rsp_id=0, rsp_result=0x4200, rsp_err=0.
REQ-033 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; never both req_ready bits high.
REQ-034 Timeout: TIMEOUT=8, unit never responds -> rsp_valid 8 cycles after entering WAIT, rsp_err=1, rsp_result=0.
REQ-035 Done on final timeout cycle (timer=TIMEOUT-1) -> rsp_err=0, rsp_result=fpu_result.
REQ-036 Backpressure: rsp_ready low 5 cycles in RESP -> outputs stable, req_ready stays 0, stray fpu_done ignored.
REQ-037 Reset asserted in WAIT -> next cycle all outputs at reset values; subsequent fpu_done produces no rsp_valid.

Source files
------------

// File: rtl/float_op_scheduler.sv
// Arbitrates two requesters onto one shared floating-point unit, tracks the
// outstanding operation with a timeout, and returns the result to its owner.
module float_op_scheduler #(
  parameter int NM      = 10,
  parameter int NE      = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [3:0]            req_op,
  input  logic [2*(1+NE+NM)-1:0] req_a,
  input  logic [2*(1+NE+NM)-1:0] req_b,
  output logic                  fpu_start,
  output logic [1:0]            fpu_op,
  output logic [NE+NM:0]        fpu_a,
  output logic [NE+NM:0]        fpu_b,
  input  logic                  fpu_done,
  input  logic [NE+NM:0]        fpu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [NE+NM:0]        rsp_result,
  output logic                  rsp_err,
  output logic                  busy
);

  // state | meaning
  // IDLE  | arbitrate, accept one command
  // ISSUE | one-cycle fpu_start pulse
  // WAIT  | wait for fpu_done or timeout
  // RESP  | hold response until rsp_ready
  localparam int W  = 1 + NE + NM;
  localparam int TW = 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          last_id_q, last_id_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          id_q, id_d;
  logic          err_q, err_d;
  logic          grant;

  always_comb begin
    if (req_valid == 2'b11) grant = ~last_id_q;
    else                    grant = req_valid[1];
  end

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    timer_d   = timer_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    id_d      = id_q;
    err_d     = err_q;
    req_ready = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (!reset && req_valid[grant]) begin
          req_ready[grant] = 1'b1;
          op_d    = grant ? req_op[3:2] : req_op[1:0];
          a_d     = grant ? req_a[2*W-1:W] : req_a[W-1:0];
          b_d     = grant ? req_b[2*W-1:W] : req_b[W-1:0];
          id_d    = grant;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // timer counts the WAIT cycles still allowed; zero is the last one
        timer_d = TW'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fpu_done) begin
          result_d = fpu_result;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (timer_q == '0) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          last_id_d = id_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_id_q <= 1'b1;
      timer_q   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      timer_q   <= timer_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      id_q      <= id_d;
      err_q     <= err_d;
    end
  end

  assign fpu_start  = (state_q == S_ISSUE);
  assign fpu_op     = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
